// File: rtl/enc4x2_event.sv
// -----------------------------------------------------------------------------
// enc4x2_event
//
// Sequential event encoder. It detects rising edges on N request lines and
// latches them as pending events. One event at a time is presented as a binary
// index on a valid/ready port. When several events are pending, the highest
// index goes first.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears all state
//   enable   : 1 = capture new rising edges, 0 = discard them (drain continues)
//   xin      : N request lines, synchronous to clk
//   yout     : W-bit index of the presented event
//   valid    : yout holds an event
//   ready    : consumer accepts yout when valid & ready at a rising edge
//   pending  : registered vector of captured, not yet presented events
//   overrun  : one-cycle pulse, an edge hit a bit that was already pending
// -----------------------------------------------------------------------------
module enc4x2_event #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic [N-1:0] xin,
   output logic [W-1:0] yout,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         overrun
);

   // The encoder maps index i to bit i. N must be a power of two and W must
   // be exactly its log2, otherwise indices and lines do not line up.
   if (N < 2 || (1 << W) != N) begin : g_bad_param
      $error("enc4x2_event: N must be a power of two >= 2 and W == clog2(N)");
   end

   // Returns the index of the highest set bit. The caller guarantees that
   // vec is nonzero.
   function automatic logic [W-1:0] f_top_index(input logic [N-1:0] vec);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = W'(i);
      end
      return idx;
   endfunction

   logic [N-1:0] r_xin_d;
   logic [N-1:0] r_pending;
   logic [W-1:0] r_yout;
   logic         r_valid;
   logic         r_overrun;

   logic [N-1:0] w_edge;
   logic [N-1:0] w_capture;
   logic         w_slot_free;
   logic         w_load;
   logic [W-1:0] w_load_idx;
   logic [N-1:0] w_load_mask;
   logic [N-1:0] w_pending_kept;
   logic [N-1:0] w_pending_next;
   logic         w_overrun;

   // Edge detect. While enable is low, edges are dropped rather than deferred.
   // r_xin_d still tracks xin, so a line that is already high when enable
   // rises produces no event.
   assign w_edge    = xin & ~r_xin_d;
   assign w_capture = enable ? w_edge : '0;

   // The slot can take a new code when it is empty, or when the current code
   // is being accepted in this cycle.
   assign w_slot_free = ~r_valid | ready;
   assign w_load      = w_slot_free & (|r_pending);
   assign w_load_idx  = f_top_index(r_pending);
   assign w_load_mask = w_load ? (N'(1) << w_load_idx) : '0;

   // The load decision uses the pending value from before this edge.
   // Edges captured now can only be loaded in a later cycle. A bit that is
   // loaded and re-captured in the same cycle ends up set again, so both
   // events are delivered.
   assign w_pending_kept = r_pending & ~w_load_mask;
   assign w_pending_next = w_pending_kept | w_capture;

   // An event is lost only when its bit is still pending after this cycle's
   // load. An edge on the bit now sitting in the output slot is not a loss.
   assign w_overrun = |(w_capture & w_pending_kept);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xin_d   <= '0;
         r_pending <= '0;
         r_yout    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_xin_d   <= xin;
         r_pending <= w_pending_next;
         r_overrun <= w_overrun;
         if (w_slot_free) begin
            if (w_load) begin
               r_yout  <= w_load_idx;
               r_valid <= 1'b1;
            end else begin
               // Nothing to present. yout keeps its last code.
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign yout    = r_yout;
   assign valid   = r_valid;
   assign pending = r_pending;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_enc4x2_event.sv
module tb_enc4x2_event;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [N-1:0] xin;
   logic [W-1:0] yout;
   logic         valid;
   logic         ready;
   logic [N-1:0] pending;
   logic         overrun;

   enc4x2_event #(.N(N), .W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .xin     (xin),
      .yout    (yout),
      .valid   (valid),
      .ready   (ready),
      .pending (pending),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: events held per line, one output slot.
   bit m_pend [N];
   bit m_prev [N];
   bit m_valid;
   int m_yout;
   bit m_ovr;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] model_pend_vec();
      logic [31:0] v;
      v = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) v += (32'd1 << i);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_prev[i] = 0;
      end
      m_valid = 0;
      m_yout  = 0;
      m_ovr   = 0;
   endtask

   // One rising edge of the reference model, from the inputs present before it.
   task automatic model_step(input logic [N-1:0] x, input logic en, input logic rd);
      int ld;
      bit nxt [N];
      bit free;
      free = !m_valid || rd;
      ld = -1;
      if (free) begin
         for (int i = N - 1; i >= 0; i--) if (m_pend[i] && ld < 0) ld = i;
      end
      m_ovr = 0;
      for (int i = 0; i < N; i++) begin
         nxt[i] = m_pend[i] && (i != ld);
         if (en && x[i] && !m_prev[i]) begin
            if (nxt[i]) m_ovr = 1;
            nxt[i] = 1;
         end
      end
      if (free) begin
         if (ld >= 0) begin
            m_yout  = ld;
            m_valid = 1;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         m_pend[i] = nxt[i];
         m_prev[i] = x[i];
      end
   endtask

   task automatic compare_model();
      check_eq("yout",    32'(yout),    32'(m_yout));
      check_eq("valid",   32'(valid),   32'(m_valid));
      check_eq("pending", 32'(pending), model_pend_vec());
      check_eq("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   // Drive inputs, take one edge, then compare 1 time unit after it.
   task automatic cycle(input logic [N-1:0] x, input logic en, input logic rd);
      xin    = x;
      enable = en;
      ready  = rd;
      @(posedge clk);
      cyc++;
      model_step(x, en, rd);
      #1;
      compare_model();
   endtask

   // Assert reset between edges and check that the outputs clear before the
   // next edge arrives.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_eq({tag, "_valid"},   32'(valid),   0);
      check_eq({tag, "_yout"},    32'(yout),    0);
      check_eq({tag, "_pending"}, 32'(pending), 0);
      check_eq({tag, "_overrun"}, 32'(overrun), 0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      xin    = '0;
      enable = 1'b1;
      ready  = 1'b1;
      model_reset();
      #3;
      check_eq("rst_valid",   32'(valid),   0);
      check_eq("rst_yout",    32'(yout),    0);
      check_eq("rst_pending", 32'(pending), 0);
      check_eq("rst_overrun", 32'(overrun), 0);
      #4;
      rst_n = 1'b1;

      // 1: single pulse on line 2
      cycle(4'b0100, 1, 1);
      check_eq("t1_pend_e0", 32'(pending), 32'h4);
      check_eq("t1_valid_e0", 32'(valid), 0);
      cycle(4'b0000, 1, 1);
      check_eq("t1_yout", 32'(yout), 2);
      check_eq("t1_valid", 32'(valid), 1);
      cycle(4'b0000, 1, 1);
      check_eq("t1_valid_off", 32'(valid), 0);

      // 2: three simultaneous edges drain highest first
      cycle(4'b1011, 1, 1);
      check_eq("t2_pend", 32'(pending), 32'hB);
      cycle(4'b0000, 1, 1);
      check_eq("t2_y3", 32'(yout), 3);
      cycle(4'b0000, 1, 1);
      check_eq("t2_y1", 32'(yout), 1);
      cycle(4'b0000, 1, 1);
      check_eq("t2_y0", 32'(yout), 0);
      check_eq("t2_v0", 32'(valid), 1);
      cycle(4'b0000, 1, 1);
      check_eq("t2_done_valid", 32'(valid), 0);
      check_eq("t2_done_pend", 32'(pending), 0);

      // 3: backpressure
      cycle(4'b0010, 1, 0);
      cycle(4'b0000, 1, 0);
      check_eq("t3_y1", 32'(yout), 1);
      cycle(4'b1000, 1, 0);
      check_eq("t3_hold_y", 32'(yout), 1);
      check_eq("t3_hold_v", 32'(valid), 1);
      check_eq("t3_pend", 32'(pending), 32'h8);
      cycle(4'b0000, 1, 1);
      check_eq("t3_y3", 32'(yout), 3);
      cycle(4'b0000, 1, 1);
      check_eq("t3_done", 32'(valid), 0);

      // 4: overrun while stalled
      cycle(4'b0101, 1, 0);
      cycle(4'b0000, 1, 0);
      check_eq("t4_slot", 32'(yout), 2);
      check_eq("t4_pend", 32'(pending), 32'h1);
      cycle(4'b0001, 1, 0);
      check_eq("t4_ovr", 32'(overrun), 1);
      cycle(4'b0000, 1, 0);
      check_eq("t4_ovr_off", 32'(overrun), 0);
      cycle(4'b0000, 1, 1);
      check_eq("t4_y0", 32'(yout), 0);
      cycle(4'b0000, 1, 1);
      check_eq("t4_once", 32'(valid), 0);

      // 5: enable low discards edges; high lines later give nothing
      cycle(4'b1111, 0, 1);
      cycle(4'b1111, 1, 1);
      check_eq("t5_pend", 32'(pending), 0);
      cycle(4'b1111, 1, 1);
      check_eq("t5_valid", 32'(valid), 0);
      cycle(4'b0000, 1, 1);

      // 6: asynchronous reset mid-transfer
      cycle(4'b1000, 1, 0);
      cycle(4'b0110, 1, 0);
      check_eq("t6_pend", 32'(pending), 32'h6);
      check_eq("t6_valid", 32'(valid), 1);
      xin = 4'b0000;
      async_reset("t6");
      for (int k = 0; k < 4; k++) cycle(4'b0000, 1, 1);
      check_eq("t6_after", 32'(valid), 0);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] x;
         logic en, rd;
         x  = N'($urandom_range(0, (1 << N) - 1));
         en = ($urandom_range(0, 7) != 0);
         rd = ($urandom_range(0, 3) != 0);
         cycle(x, en, rd);
         if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
